// File: rtl/keypad_pkg.sv
// Shared types, keypad geometry and the snapshot classifier for the keypad
// scanner.
package keypad_pkg;

  localparam int unsigned NUM_COLS = 4;
  localparam int unsigned NUM_ROWS = 4;
  localparam int unsigned NUM_KEYS = NUM_COLS * NUM_ROWS;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_PRESSED,
    ST_RELEASING
  } state_t;

  typedef enum logic [1:0] {
    CLS_NONE,
    CLS_SINGLE,
    CLS_MULTI
  } class_t;

  typedef logic [3:0] key_code_t;

  typedef struct packed {
    class_t    cls;
    key_code_t key;
  } frame_class_t;

  // The key index is the snapshot bit position, i.e. {column, row}.
  function automatic frame_class_t classify_snapshot(input logic [NUM_KEYS-1:0] snap);
    frame_class_t res;
    logic [4:0]   cnt;
    res.cls = CLS_NONE;
    res.key = '0;
    cnt     = '0;
    for (int unsigned i = 0; i < NUM_KEYS; i++) begin
      if (snap[i]) begin
        cnt     = cnt + 5'd1;
        res.key = key_code_t'(i);
      end
    end
    if (cnt == 5'd1) begin
      res.cls = CLS_SINGLE;
    end else if (cnt != '0) begin
      res.cls = CLS_MULTI;
    end
    return res;
  endfunction

endpackage

// File: rtl/row_sync.sv
// Two-flop synchronizer that brings the asynchronous keypad rows into the
// scanner clock domain.
module row_sync
  import keypad_pkg::*;
(
  input  logic                i_clock,
  input  logic                i_reset,
  input  logic [NUM_ROWS-1:0] i_rows,
  output logic [NUM_ROWS-1:0] o_rows
);

  logic [NUM_ROWS-1:0] r_meta;
  logic [NUM_ROWS-1:0] r_sync;

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      r_meta <= '0;
      r_sync <= '0;
    end else begin
      r_meta <= i_rows;
      r_sync <= r_meta;
    end
  end

  assign o_rows = r_sync;

endmodule

// File: rtl/keypad_scan_ctrl.sv
// 4x4 keypad scanner: column drive, per-frame snapshot, frame-level debounce
// and single-key press/release tracking with a one-cycle valid pulse.
module keypad_scan_ctrl
  import keypad_pkg::*;
#(
  parameter int unsigned SCAN_DIV       = 8,
  parameter int unsigned DEBOUNCE_SCANS = 3
) (
  input  logic                clock,
  input  logic                reset,
  input  logic [NUM_ROWS-1:0] rowIn,
  output logic [NUM_COLS-1:0] colOut,
  output key_code_t           keyCode,
  output logic                keyValid,
  output logic                keyHeld
);

  localparam int unsigned     DW         = $clog2(SCAN_DIV);
  localparam int unsigned     MW         = $clog2(DEBOUNCE_SCANS + 1);
  localparam logic [DW-1:0]   DWELL_LAST = DW'(SCAN_DIV - 1);
  localparam logic [MW-1:0]   MATCH_MAX  = MW'(DEBOUNCE_SCANS);
  localparam logic [1:0]      COL_LAST   = 2'(NUM_COLS - 1);

  logic [NUM_ROWS-1:0] w_rows;
  logic                w_sample;

  logic [DW-1:0]       r_dwell;
  logic [1:0]          r_col;
  logic [NUM_COLS-1:0] r_col_out;
  logic [NUM_KEYS-1:0] r_snap;
  logic                r_frame_done;

  state_t              r_state;
  frame_class_t        r_prev;
  logic [MW-1:0]       r_match;
  key_code_t           r_key_code;
  logic                r_key_valid;
  logic                r_key_held;

  frame_class_t        w_cls;
  logic                w_same;
  logic [MW-1:0]       w_match_next;
  logic                w_match_full;
  logic                w_is_held_key;

  row_sync u_row_sync (
    .i_clock (clock),
    .i_reset (reset),
    .i_rows  (rowIn),
    .o_rows  (w_rows)
  );

  assign w_sample = (r_dwell == DWELL_LAST);

  // Column 0 overwrites the whole snapshot so every frame starts clean.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_dwell      <= '0;
      r_col        <= '0;
      r_col_out    <= 4'b0001;
      r_snap       <= '0;
      r_frame_done <= 1'b0;
    end else begin
      r_frame_done <= w_sample && (r_col == COL_LAST);
      if (w_sample) begin
        r_dwell   <= '0;
        r_col     <= r_col + 1'b1;
        r_col_out <= {r_col_out[NUM_COLS-2:0], r_col_out[NUM_COLS-1]};
        if (r_col == '0) begin
          r_snap <= NUM_KEYS'(w_rows);
        end else begin
          r_snap[{r_col, 2'b00} +: NUM_ROWS] <= w_rows;
        end
      end else begin
        r_dwell <= r_dwell + 1'b1;
      end
    end
  end

  assign w_cls         = classify_snapshot(r_snap);
  assign w_same        = (w_cls.cls == r_prev.cls) &&
                         ((w_cls.cls != CLS_SINGLE) || (w_cls.key == r_prev.key));
  assign w_match_next  = !w_same ? MW'(1) :
                         ((r_match == MATCH_MAX) ? MATCH_MAX : r_match + 1'b1);
  assign w_match_full  = (w_match_next == MATCH_MAX);
  assign w_is_held_key = (w_cls.cls == CLS_SINGLE) && (w_cls.key == r_key_code);

  // Direct PRESSED->IDLE only matters when a single NONE frame already satisfies the debounce.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state     <= ST_IDLE;
      r_prev.cls  <= CLS_NONE;
      r_prev.key  <= '0;
      r_match     <= '0;
      r_key_code  <= '0;
      r_key_valid <= 1'b0;
      r_key_held  <= 1'b0;
    end else begin
      r_key_valid <= 1'b0;
      if (r_frame_done) begin
        r_prev  <= w_cls;
        r_match <= w_match_next;
        case (r_state)
          ST_IDLE: begin
            if ((w_cls.cls == CLS_SINGLE) && w_match_full) begin
              r_state     <= ST_PRESSED;
              r_key_code  <= w_cls.key;
              r_key_valid <= 1'b1;
              r_key_held  <= 1'b1;
            end
          end
          ST_PRESSED: begin
            if (!w_is_held_key) begin
              if ((w_cls.cls == CLS_NONE) && w_match_full) begin
                r_state    <= ST_IDLE;
                r_key_held <= 1'b0;
              end else begin
                r_state <= ST_RELEASING;
              end
            end
          end
          ST_RELEASING: begin
            if (w_is_held_key) begin
              r_state <= ST_PRESSED;
            end else if ((w_cls.cls == CLS_NONE) && w_match_full) begin
              r_state    <= ST_IDLE;
              r_key_held <= 1'b0;
            end
          end
          default: r_state <= ST_IDLE;
        endcase
      end
    end
  end

  assign colOut   = r_col_out;
  assign keyCode  = r_key_code;
  assign keyValid = r_key_valid;
  assign keyHeld  = r_key_held;

endmodule
